pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised successor to the 4-bit program counter: an ADDR_W-bit program counter with increment, load, and bus-drive controls, plus a STACK_DEPTH-entry return-address stack for CALL/RET. It sits on the CPU bus next to the control block. It takes CP/EP/LP from the control word, and CALL/RET from the extended control word. It reports stack status and sticky error flags to the control block for halt/trap decisions.

## Interface
- ADDR_W, 4: program counter and bus address width; must be at least 2.
- STACK_DEPTH, 4: number of return-address entries; a power of two, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bits_in  in  ADDR_W  bus value used by load and call.
- cp  in  1  count enable: increment PC.
- ep  in  1  enable output: drive PC onto bits_out.
- lp  in  1  load PC from bits_in.
- call  in  1  push the current PC, then load PC from bits_in.
- ret  in  1  pop the top of stack into PC.
- err_clr  in  1  clear the sticky error flags.
- bits_out  out  ADDR_W  PC value when ep=1, otherwise all zeros.
- pc  out  ADDR_W  current PC, always visible (debug pins).
- stack_empty  out  1  high when no entries are held.
- stack_full  out  1  high when STACK_DEPTH entries are held.
- ovf_err  out  1  sticky flag: a call was issued while the stack was full.
- unf_err  out  1  sticky flag: a ret was issued while the stack was empty.

## Operation
- Reset values: pc=0, stack count=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0, bits_out=0. Stack entry contents are don't-care after reset.
- Per-cycle action priority is rst > ret > call > lp > cp. Exactly one action executes per cycle. Lower-priority requests in the same cycle are dropped, not queued.
- **cp:** pc ← pc+1 modulo 2^ADDR_W; the maximum value wraps to 0 silently.
- **lp:** pc ← bits_in.
- **call, not full:**
  - mem[count] ← pc, with the pre-call PC pushed as-is (no +1).
  - count ← count+1.
  - pc ← bits_in.
- **call, full:**
  - No push and no PC change.
  - ovf_err ← 1.
- **ret, not empty:** pc ← mem[count-1]; count ← count-1.
- **ret, empty:**
  - PC unchanged.
  - unf_err ← 1.
- **err_clr:** clears both error flags.
  - err_clr is independent of the action priority and is applied in the same cycle as any action.
  - If an error-setting event coincides with err_clr, set wins.
- **Bus output:** bits_out = ep ? pc : 0. This is combinational from the registered pc; there is no tristate.
- **Count range:** the occupancy counter is $clog2(STACK_DEPTH)+1 bits wide and never leaves the range 0..STACK_DEPTH.
- **Flags:** stack_full and stack_empty are decoded from count.

## Timing
- All state changes are visible on outputs the cycle after the requesting edge. Effective latency is 1 cycle.
- bits_out follows ep combinationally within the same cycle.
- Back-to-back call then ret returns the original PC at cycle N+2.
- A call when count=STACK_DEPTH-1 asserts stack_full the next cycle. A further call in that cycle sets ovf_err.
- A reset asserted mid-sequence discards the stack in one cycle. pc=0 on the following cycle regardless of the other inputs.
- No combinational path exists from call/ret/lp/cp to any output.

## Structure
- Shared package cpu_pkg holds:
  - control-word bit indices (CW_CP=14, CW_EP=13, CW_LP=12, CW_CALL, CW_RET);
  - the default ADDR_W;
  - an enum for the resolved action {ACT_NONE, ACT_INC, ACT_LOAD, ACT_CALL, ACT_RET}.
- Sub-module lifo_stack (parameters: WIDTH, DEPTH) provides:
  - push/pop/din/dout and full/empty signals;
  - registered storage with a count pointer.
- pc_stack_unit resolves priority into the action enum and owns the PC register and error flags.

## Test plan
- **Reset and wrap (ADDR_W=4):** rst=1 for one cycle, then cp held high for 17 cycles. Expected: pc 0,1,…,15,0,1; bits_out=0 while ep=0 and equals pc while ep=1.
- **Load priority:** pc=3, drive lp=1, cp=1, bits_in=9 in the same cycle. Expected: pc=9 next cycle, not 4 or 10.
- **Call/return:** pc=5, call with bits_in=12, then cp ×2, then ret. Expected:
  - pc sequence 12, 13, 14, 5;
  - stack_empty goes 0 after the call and 1 after the ret.
- **Overflow (STACK_DEPTH=4):** five consecutive calls with bits_in=1..5 from pc=0. Expected:
  - after the 4th call, stack_full=1 and pc=4;
  - the 5th call leaves pc=4 and sets ovf_err=1;
  - four rets then yield pc 3, 2, 1, 0.
- **Underflow and clear:** ret with an empty stack at pc=7. Expected:
  - pc stays 7 and unf_err=1 persists across idle cycles;
  - err_clr=1 clears it next cycle;
  - ret+err_clr together on an empty stack leaves unf_err=1.
- **Reset mid-operation:** push 3 entries, assert rst together with ret. Expected: next cycle pc=0, stack_empty=1, both error flags 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word bit positions, default bus width and
// the resolved per-cycle action of the program counter / stack unit.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;

    localparam int unsigned CW_CP = 14;
    localparam int unsigned CW_EP = 13;
    localparam int unsigned CW_LP = 12;
    // CALL/RET live in the extended control word
    localparam int unsigned CW_CALL = 1;
    localparam int unsigned CW_RET  = 0;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INC,
        ACT_LOAD,
        ACT_CALL,
        ACT_RET
    } act_e;

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: registered storage with an occupancy counter.
// Push into a full stack or pop from an empty one is ignored; pop wins over push.
module lifo_stack
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~pop & ~full;
    assign dout    = mem_q[IDX_W'(cnt_q - CNT_W'(1))];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (do_push) begin
            mem_d[IDX_W'(cnt_q)] = din;
            cnt_d                = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; the counter alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment/load/bus-drive plus a return-address stack
// for CALL/RET, reporting stack status and sticky overflow/underflow flags.
module pc_stack_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bits_in,
    input  logic              cp,
    input  logic              ep,
    input  logic              lp,
    input  logic              call,
    input  logic              ret,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] bits_out,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              unf_err
);

    act_e              act;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_push, stk_pop;
    logic              ovf_set, unf_set;

    always_comb begin
        if (ret) begin
            act = ACT_RET;
        end else if (call) begin
            act = ACT_CALL;
        end else if (lp) begin
            act = ACT_LOAD;
        end else if (cp) begin
            act = ACT_INC;
        end else begin
            act = ACT_NONE;
        end
    end

    assign stk_push = (act == ACT_CALL);
    assign stk_pop  = (act == ACT_RET);
    assign ovf_set  = (act == ACT_CALL) & stack_full;
    assign unf_set  = (act == ACT_RET) & stack_empty;

    lifo_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_q),
        .dout  (stk_dout),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_d = pc_q;
        unique case (act)
            ACT_INC:  pc_d = pc_q + ADDR_W'(1);
            ACT_LOAD: pc_d = bits_in;
            ACT_CALL: if (!stack_full) pc_d = bits_in;
            ACT_RET:  if (!stack_empty) pc_d = stk_dout;
            default:  pc_d = pc_q;
        endcase
        // A coinciding error event beats the clear.
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        unf_d = (unf_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc       = pc_q;
    assign bits_out = ep ? pc_q : '0;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_pc_stack_unit;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] bits_in = '0;
    logic          cp = 1'b0, ep = 1'b0, lp = 1'b0, call = 1'b0, ret = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] bits_out, pc;
    logic          stack_empty, stack_full, ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int      pc_m = 0;
    int      stk_m[$];
    bit      ovf_m = 0, unf_m = 0;
    bit      model_valid = 0;

    pc_stack_unit #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bits_in     (bits_in),
        .cp          (cp),
        .ep          (ep),
        .lp          (lp),
        .call        (call),
        .ret         (ret),
        .err_clr     (err_clr),
        .bits_out    (bits_out),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then advance the model
    // with the same inputs once the rising edge has happened.
    task automatic cycle(input bit r, input bit c, input bit e, input bit l, input bit cl,
                         input bit rt, input bit ec, input int b);
        bit so, su;
        @(negedge clk);
        #1;
        rst = r; cp = c; ep = e; lp = l; call = cl; ret = rt; err_clr = ec;
        bits_in = AW'(b);
        @(posedge clk);
        so = 0;
        su = 0;
        if (r) begin
            pc_m = 0;
            stk_m.delete();
            ovf_m = 0;
            unf_m = 0;
            model_valid = 1;
        end else begin
            if (rt) begin
                if (stk_m.size() == 0) su = 1;
                else pc_m = stk_m.pop_back();
            end else if (cl) begin
                if (stk_m.size() == DEPTH) so = 1;
                else begin
                    stk_m.push_back(pc_m);
                    pc_m = b % (1 << AW);
                end
            end else if (l) begin
                pc_m = b % (1 << AW);
            end else if (c) begin
                pc_m = (pc_m + 1) % (1 << AW);
            end
            ovf_m = (ovf_m && !ec) || so;
            unf_m = (unf_m && !ec) || su;
        end
        #2;
    endtask

    task automatic idle(input bit e);
        cycle(0, 0, e, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("pc", int'(pc), pc_m);
            check("bits_out", int'(bits_out), ep ? pc_m : 0);
            check("stack_empty", int'(stack_empty), int'(stk_m.size() == 0));
            check("stack_full", int'(stack_full), int'(stk_m.size() == DEPTH));
            check("ovf_err", int'(ovf_err), int'(ovf_m));
            check("unf_err", int'(unf_err), int'(unf_m));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        cycle(1, 1, 0, 1, 1, 0, 0, 9);
        check("rst_pc", int'(pc), 0);
        check("rst_empty", int'(stack_empty), 1);
        check("rst_full", int'(stack_full), 0);
        check("rst_ovf", int'(ovf_err), 0);
        check("rst_unf", int'(unf_err), 0);

        // Count through the wrap with ep toggling
        for (int i = 0; i < 17; i++) begin
            cycle(0, 1, i[0], 0, 0, 0, 0, 0);
            if (i == 14) check("wrap_15", int'(pc), 15);
            if (i == 15) check("wrap_0", int'(pc), 0);
        end
        check("wrap_1", int'(pc), 1);
        ep = 1'b1;
        #1 check("bits_out_ep", int'(bits_out), 1);

        // Load beats increment
        cycle(0, 0, 0, 1, 0, 0, 0, 3);
        cycle(0, 1, 0, 1, 0, 0, 0, 9);
        check("load_prio", int'(pc), 9);

        // Call / return
        cycle(0, 0, 0, 1, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 1, 0, 0, 12);
        check("call_pc", int'(pc), 12);
        check("call_empty", int'(stack_empty), 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("call_cp2", int'(pc), 14);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check("ret_pc", int'(pc), 5);
        check("ret_empty", int'(stack_empty), 1);

        // Overflow
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 0, 0, 0, 1, 0, 0, i);
            if (i == 3) check("ovf_nfull3", int'(stack_full), 0);
            if (i == 4) begin
                check("ovf_full4", int'(stack_full), 1);
                check("ovf_pc4", int'(pc), 4);
            end
        end
        check("ovf_pc5", int'(pc), 4);
        check("ovf_flag", int'(ovf_err), 1);
        for (int i = 3; i >= 0; i--) begin
            cycle(0, 0, 0, 0, 0, 1, 0, 0);
            check("ovf_ret_pc", int'(pc), i);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check("ovf_clr", int'(ovf_err), 0);

        // Underflow and clear
        cycle(0, 0, 0, 1, 0, 0, 0, 7);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check("unf_pc", int'(pc), 7);
        check("unf_flag", int'(unf_err), 1);
        idle(0);
        idle(1);
        check("unf_sticky", int'(unf_err), 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check("unf_clr", int'(unf_err), 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        check("unf_set_wins", int'(unf_err), 1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0, 10 + i);
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        check("mid_rst_pc", int'(pc), 0);
        check("mid_rst_empty", int'(stack_empty), 1);
        check("mid_rst_unf", int'(unf_err), 0);
        check("mid_rst_ovf", int'(ovf_err), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
        end

        idle(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
